// File: rtl/frame_wr_sequencer.sv
// rtl/frame_wr_sequencer.sv - mem-clock burst write sequencer for the camera capture path
// Issues burst write requests from the CDC FIFO fill level between frame_valid edges.
module frame_wr_sequencer #(
  parameter int ADDR_W      = 29,
  parameter int COUNT_W     = 9,
  parameter int BURST_LEN   = 1,
  parameter int ADDR_INC    = 8,
  parameter int MAX_BURSTS  = 65536,
  parameter int CNT_W       = 17,
  parameter int RST_CYCLES  = 12,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_valid,
  input  logic [ADDR_W-1:0]  start_addr,
  input  logic [COUNT_W-1:0] fifo_rd_data_count,
  input  logic               fifo_empty,
  input  logic               mem_wr_ack,
  output logic               mem_wr_req,
  output logic [ADDR_W-1:0]  mem_wr_addr,
  output logic               mem_wr_partial,
  output logic               fifo_reset,
  output logic               ready,
  output logic               frame_written,
  output logic [CNT_W-1:0]   burst_count,
  output logic               overrun,
  output logic               timeout
);

  localparam int TMR_MAX = (RST_CYCLES > ACK_TIMEOUT) ? RST_CYCLES : ACK_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0]   RST_LAST    = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0]   ACK_LAST    = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [COUNT_W-1:0] BURST_WORDS = COUNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]   BURST_LIMIT = CNT_W'(MAX_BURSTS);
  localparam logic [ADDR_W-1:0]  ADDR_STEP   = ADDR_W'(ADDR_INC);

  typedef enum logic [2:0] {RST_WAIT, IDLE, WRITE, REQ, FLUSH} state_t;

  state_t             state, state_d;
  logic [1:0]         rst_sync;
  logic               rst_n_i;
  logic               fv_meta, fv_s, fv_q, start;
  logic [TMR_W-1:0]   tmr, tmr_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [CNT_W-1:0]   count_d;
  logic               overrun_d, timeout_d, fw_d;
  logic               have_burst, have_partial;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_i = rst_sync[1];

  assign start          = fv_s & ~fv_q;
  assign have_burst     = fifo_rd_data_count >= BURST_WORDS;
  assign have_partial   = (fifo_rd_data_count != '0) && (fifo_rd_data_count < BURST_WORDS);
  assign mem_wr_req     = (state == REQ) || (state == FLUSH);
  assign mem_wr_partial = (state == FLUSH);
  assign fifo_reset     = (state == RST_WAIT);
  assign ready          = (state == IDLE);

  always_comb begin
    state_d   = state;
    tmr_d     = tmr;
    addr_d    = mem_wr_addr;
    count_d   = burst_count;
    overrun_d = overrun;
    timeout_d = timeout;
    fw_d      = 1'b0;
    case (state)
      RST_WAIT: begin
        if (tmr == RST_LAST) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr + 1'b1;
        end
      end
      IDLE: begin
        if (start) begin
          state_d   = WRITE;
          addr_d    = start_addr;
          count_d   = '0;
          overrun_d = 1'b0;
          timeout_d = 1'b0;
        end
      end
      WRITE: begin
        if (have_burst && (burst_count < BURST_LIMIT)) begin
          state_d = REQ;
          tmr_d   = '0;
        end else if (have_burst) begin
          overrun_d = 1'b1;
        end else if (!fv_s && (overrun || fifo_empty)) begin
          state_d = RST_WAIT;
          tmr_d   = '0;
          fw_d    = 1'b1;
        end else if (!fv_s && have_partial && !overrun) begin
          state_d = FLUSH;
          tmr_d   = '0;
        end
      end
      REQ, FLUSH: begin
        if (mem_wr_ack) begin
          addr_d  = mem_wr_addr + ADDR_STEP;
          count_d = burst_count + 1'b1;
          if (state == FLUSH) begin
            state_d = RST_WAIT;
            tmr_d   = '0;
            fw_d    = 1'b1;
          end else begin
            state_d = WRITE;
          end
        end else if (tmr == ACK_LAST) begin
          // Arbiter stalled: abandon the frame rather than hang the capture path.
          state_d   = RST_WAIT;
          tmr_d     = '0;
          timeout_d = 1'b1;
          fw_d      = 1'b1;
        end else begin
          tmr_d = tmr + 1'b1;
        end
      end
      default: begin
        state_d = RST_WAIT;
        tmr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= RST_WAIT;
      tmr           <= '0;
      fv_meta       <= 1'b0;
      fv_s          <= 1'b0;
      fv_q          <= 1'b0;
      mem_wr_addr   <= '0;
      burst_count   <= '0;
      overrun       <= 1'b0;
      timeout       <= 1'b0;
      frame_written <= 1'b0;
    end else begin
      state         <= state_d;
      tmr           <= tmr_d;
      fv_meta       <= frame_valid;
      fv_s          <= fv_meta;
      fv_q          <= fv_s;
      mem_wr_addr   <= addr_d;
      burst_count   <= count_d;
      overrun       <= overrun_d;
      timeout       <= timeout_d;
      frame_written <= fw_d;
    end
  end

endmodule

// File: tb/tb_frame_wr_sequencer.sv
// tb/tb_frame_wr_sequencer.sv - directed self-checking bench for frame_wr_sequencer
// Instance uses BURST_LEN=4, ADDR_INC=32, MAX_BURSTS=3, RST_CYCLES=12, ACK_TIMEOUT=20.
module tb_frame_wr_sequencer;

  logic        clk;
  logic        reset_n;
  logic        frame_valid;
  logic [28:0] start_addr;
  logic [8:0]  rd_count;
  logic        fifo_empty;
  logic        mem_wr_ack;
  logic        mem_wr_req;
  logic [28:0] mem_wr_addr;
  logic        mem_wr_partial;
  logic        fifo_reset;
  logic        ready;
  logic        frame_written;
  logic [3:0]  burst_count;
  logic        overrun;
  logic        timeout;

  int n_cmp = 0;
  int n_err = 0;

  int          n_req, n_fw, rst_len, req_cycles;
  bit          frame_ok;
  logic [28:0] first_addr;
  logic [28:0] req_addr [8];
  logic        req_part [8];

  assign fifo_empty = (rd_count == 9'd0);

  frame_wr_sequencer #(
    .ADDR_W(29), .COUNT_W(9), .BURST_LEN(4), .ADDR_INC(32), .MAX_BURSTS(3),
    .CNT_W(4), .RST_CYCLES(12), .ACK_TIMEOUT(20)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame_valid(frame_valid), .start_addr(start_addr),
    .fifo_rd_data_count(rd_count), .fifo_empty(fifo_empty), .mem_wr_ack(mem_wr_ack),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_partial(mem_wr_partial),
    .fifo_reset(fifo_reset), .ready(ready), .frame_written(frame_written),
    .burst_count(burst_count), .overrun(overrun), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Plays one frame: raises frame_valid, acks requests (if enabled) and drains the
  // modelled FIFO, drops frame_valid when data runs short, and returns once ready again.
  task automatic do_frame(input int words, input logic [28:0] base, input bit ack_en);
    bit pending_ack, pend_partial, started;
    n_req = 0; n_fw = 0; rst_len = 0; req_cycles = 0; frame_ok = 0;
    first_addr = '0; pending_ack = 0; pend_partial = 0; started = 0;
    start_addr  = base;
    rd_count    = 9'(words);
    frame_valid = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (pending_ack) begin
        mem_wr_ack  = 1'b0;
        pending_ack = 0;
        rd_count    = pend_partial ? 9'd0 : rd_count - 9'd4;
      end
      if (!ready) started = 1;
      if (frame_written) n_fw++;
      if (n_fw > 0 && fifo_reset) rst_len++;
      if (n_fw > 0 && ready) begin
        frame_ok = 1;
        break;
      end
      if (mem_wr_req) begin
        if (req_cycles == 0) first_addr = mem_wr_addr;
        req_cycles++;
        if (ack_en && n_req < 8) begin
          req_addr[n_req] = mem_wr_addr;
          req_part[n_req] = mem_wr_partial;
          n_req++;
          mem_wr_ack   = 1'b1;
          pending_ack  = 1;
          pend_partial = mem_wr_partial;
        end
      end
      if (started && overrun && frame_valid) begin
        rd_count    = 9'd2;
        frame_valid = 1'b0;
      end
      if (rd_count < 9'd4 && !pending_ack) frame_valid = 1'b0;
    end
    frame_valid = 1'b0;
    mem_wr_ack  = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    bit got_ready;
    reset_n = 1'b0; frame_valid = 1'b0; start_addr = '0; rd_count = '0; mem_wr_ack = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (fifo_reset !== 1'b1) begin n_err++; $display("FAIL reset_fifo_reset: got %b expected 1", fifo_reset); end
    n_cmp++; if ({mem_wr_req, mem_wr_partial, ready, frame_written, overrun, timeout} !== 6'b0) begin
      n_err++; $display("FAIL reset_flags: got %b expected 000000", {mem_wr_req, mem_wr_partial, ready, frame_written, overrun, timeout});
    end
    n_cmp++; if (mem_wr_addr !== 29'h0 || burst_count !== 4'd0) begin
      n_err++; $display("FAIL reset_addr_count: got %h/%0d expected 0/0", mem_wr_addr, burst_count);
    end
    reset_n = 1'b1;
    got_ready = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) begin got_ready = 1; break; end
    end
    n_cmp++; if (!got_ready) begin n_err++; $display("FAIL reset_ready: got 0 expected 1 within 40 cycles"); end
  endtask

  task automatic test_full_bursts;
    do_frame(12, 29'h100, 1);
    n_cmp++; if (!frame_ok) begin n_err++; $display("FAIL full_done: got 0 expected 1"); end
    n_cmp++; if (n_req != 3) begin n_err++; $display("FAIL full_nreq: got %0d expected 3", n_req); end
    n_cmp++; if (req_addr[0] !== 29'h100 || req_addr[1] !== 29'h120 || req_addr[2] !== 29'h140) begin
      n_err++; $display("FAIL full_addrs: got %h %h %h expected 100 120 140", req_addr[0], req_addr[1], req_addr[2]);
    end
    n_cmp++; if (req_part[0] | req_part[1] | req_part[2]) begin n_err++; $display("FAIL full_partial: got 1 expected 0"); end
    n_cmp++; if (burst_count !== 4'd3) begin n_err++; $display("FAIL full_count: got %0d expected 3", burst_count); end
    n_cmp++; if (n_fw != 1) begin n_err++; $display("FAIL full_fw: got %0d expected 1", n_fw); end
    n_cmp++; if (rst_len != 12) begin n_err++; $display("FAIL full_rst_len: got %0d expected 12", rst_len); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL full_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_flush;
    do_frame(10, 29'h100, 1);
    n_cmp++; if (n_req != 3) begin n_err++; $display("FAIL flush_nreq: got %0d expected 3", n_req); end
    n_cmp++; if (req_addr[2] !== 29'h140 || req_part[2] !== 1'b1) begin
      n_err++; $display("FAIL flush_req: got %h/%b expected 140/1", req_addr[2], req_part[2]);
    end
    n_cmp++; if (req_part[0] | req_part[1]) begin n_err++; $display("FAIL flush_full_partial: got 1 expected 0"); end
    n_cmp++; if (burst_count !== 4'd3) begin n_err++; $display("FAIL flush_count: got %0d expected 3", burst_count); end
    n_cmp++; if (n_fw != 1) begin n_err++; $display("FAIL flush_fw: got %0d expected 1", n_fw); end
    n_cmp++; if (mem_wr_addr !== 29'h160) begin n_err++; $display("FAIL flush_next_addr: got %h expected 160", mem_wr_addr); end
  endtask

  task automatic test_overrun;
    do_frame(16, 29'h200, 1);
    n_cmp++; if (!frame_ok) begin n_err++; $display("FAIL ovr_done: got 0 expected 1"); end
    n_cmp++; if (n_req != 3) begin n_err++; $display("FAIL ovr_nreq: got %0d expected 3", n_req); end
    n_cmp++; if (req_addr[2] !== 29'h240) begin n_err++; $display("FAIL ovr_last_addr: got %h expected 240", req_addr[2]); end
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_flag: got %b expected 1", overrun); end
    n_cmp++; if (burst_count !== 4'd3) begin n_err++; $display("FAIL ovr_count: got %0d expected 3", burst_count); end
    n_cmp++; if (n_fw != 1) begin n_err++; $display("FAIL ovr_fw: got %0d expected 1", n_fw); end
  endtask

  task automatic test_timeout;
    do_frame(4, 29'h500, 0);
    n_cmp++; if (!frame_ok) begin n_err++; $display("FAIL to_done: got 0 expected 1"); end
    n_cmp++; if (req_cycles != 20) begin n_err++; $display("FAIL to_req_cycles: got %0d expected 20", req_cycles); end
    n_cmp++; if (first_addr !== 29'h500) begin n_err++; $display("FAIL to_addr: got %h expected 500", first_addr); end
    n_cmp++; if (timeout !== 1'b1) begin n_err++; $display("FAIL to_flag: got %b expected 1", timeout); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL to_overrun_cleared: got %b expected 0", overrun); end
    n_cmp++; if (burst_count !== 4'd0) begin n_err++; $display("FAIL to_count: got %0d expected 0", burst_count); end
    n_cmp++; if (n_fw != 1) begin n_err++; $display("FAIL to_fw: got %0d expected 1", n_fw); end
    n_cmp++; if (rst_len != 12) begin n_err++; $display("FAIL to_rst_len: got %0d expected 12", rst_len); end
  endtask

  task automatic test_async_reset;
    bit seen_req, got_ready;
    start_addr = 29'h400; rd_count = 9'd4; frame_valid = 1'b1;
    seen_req = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_wr_req) begin seen_req = 1; break; end
    end
    n_cmp++; if (!seen_req) begin n_err++; $display("FAIL ar_req_seen: got 0 expected 1"); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (mem_wr_req !== 1'b0 || fifo_reset !== 1'b1) begin
      n_err++; $display("FAIL ar_async: got req=%b fifo_reset=%b expected 0/1", mem_wr_req, fifo_reset);
    end
    n_cmp++; if (timeout !== 1'b0 || mem_wr_addr !== 29'h0) begin
      n_err++; $display("FAIL ar_cleared: got %b/%h expected 0/0", timeout, mem_wr_addr);
    end
    frame_valid = 1'b0; rd_count = 9'd0;
    @(negedge clk);
    reset_n = 1'b1;
    got_ready = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) begin got_ready = 1; break; end
    end
    n_cmp++; if (!got_ready) begin n_err++; $display("FAIL ar_ready: got 0 expected 1 within 40 cycles"); end
    do_frame(4, 29'h2000, 1);
    n_cmp++; if (n_req != 1 || req_addr[0] !== 29'h2000) begin
      n_err++; $display("FAIL ar_new_frame: got %0d reqs at %h expected 1 at 2000", n_req, req_addr[0]);
    end
    n_cmp++; if (burst_count !== 4'd1) begin n_err++; $display("FAIL ar_count: got %0d expected 1", burst_count); end
  endtask

  task automatic test_fv_high_at_idle;
    bit got_ready;
    int stray;
    @(negedge clk);
    reset_n = 1'b0; frame_valid = 1'b1; rd_count = 9'd8; start_addr = 29'h300;
    @(negedge clk);
    reset_n = 1'b1;
    got_ready = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) begin got_ready = 1; break; end
    end
    n_cmp++; if (!got_ready) begin n_err++; $display("FAIL fvh_ready: got 0 expected 1 within 40 cycles"); end
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_wr_req || !ready) stray++;
    end
    n_cmp++; if (stray != 0) begin n_err++; $display("FAIL fvh_no_start: got %0d busy cycles expected 0", stray); end
    frame_valid = 1'b0;
    repeat (4) @(negedge clk);
    do_frame(8, 29'h300, 1);
    n_cmp++; if (n_req != 2 || req_addr[0] !== 29'h300 || req_addr[1] !== 29'h320) begin
      n_err++; $display("FAIL fvh_frame: got %0d reqs %h %h expected 2 at 300 320", n_req, req_addr[0], req_addr[1]);
    end
    n_cmp++; if (burst_count !== 4'd2) begin n_err++; $display("FAIL fvh_count: got %0d expected 2", burst_count); end
  endtask

  initial begin
    test_reset();
    test_full_bursts();
    test_flush();
    test_overrun();
    test_timeout();
    test_async_reset();
    test_fv_high_at_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/frame_wr_sequencer.md
Name: frame_wr_sequencer

Overview:
- Parametrised mem-clock-side write sequencer for the camera capture path.
- Watches a pixel-domain frame-valid level and the CDC FIFO read-side fill level, and issues burst write requests to the memory arbiter from a latched start address.
- Generalises the fixed single-beat writer:
  - burst length, address step, FIFO count width and frame size limit are parameters;
  - a partial final burst is flushed at end of frame;
  - frames exceeding the size limit are truncated and flagged;
  - a stalled arbiter is aborted by ack timeout.

Parameters:
ADDR_W, 29, width of start/write address
COUNT_W, 9, width of FIFO read data count
BURST_LEN, 1, FIFO words (128-bit) per write request
ADDR_INC, 8, address increment per accepted request
MAX_BURSTS, 65536, max requests per frame; further data is dropped
CNT_W, 17, width of burst counter; must hold MAX_BURSTS
RST_CYCLES, 12, FIFO reset pulse length after each frame
ACK_TIMEOUT, 1024, cycles in a request state without ack before abort

Ports:
clk  in  1  memory clock
reset_n  in  1  asynchronous active-low reset
frame_valid  in  1  pixel-domain frame level; asynchronous to clk, synchronised internally
start_addr  in  ADDR_W  frame base address; sampled at frame start
fifo_rd_data_count  in  COUNT_W  CDC FIFO words available
fifo_empty  in  1  CDC FIFO empty
mem_wr_ack  in  1  arbiter accepts current request
mem_wr_req  out  1  write request, held until ack
mem_wr_addr  out  ADDR_W  address of current request
mem_wr_partial  out  1  current request is short end-of-frame burst; data path pads
fifo_reset  out  1  CDC FIFO reset
ready  out  1  idle, able to accept a frame
frame_written  out  1  one-cycle pulse at frame completion or abort
burst_count  out  CNT_W  accepted requests in current/last frame
overrun  out  1  sticky: frame exceeded MAX_BURSTS
timeout  out  1  sticky: ack timeout occurred

Behaviour:
- Reset (async assert, sync deassert internally): state RST_WAIT with counter 0. Outputs after reset:
  - fifo_reset=1;
  - mem_wr_req, mem_wr_partial, ready, frame_written, overrun, timeout = 0;
  - mem_wr_addr=0, burst_count=0.
- frame_valid passes a 2-flop synchroniser to fv_s; fv_q is the delayed copy; start = fv_s & ~fv_q.
- RST_WAIT: fifo_reset=1 for RST_CYCLES cycles, then IDLE.
- IDLE: ready=1.
  - On start: mem_wr_addr<=start_addr, burst_count<=0, overrun<=0, timeout<=0, go to WRITE.
  - A frame already high when IDLE is entered does not start; only a rising edge starts a frame.
- WRITE: evaluated in priority order.
  1. fifo_rd_data_count>=BURST_LEN and burst_count<MAX_BURSTS → REQ, mem_wr_req=1.
  2. fifo_rd_data_count>=BURST_LEN and burst_count==MAX_BURSTS → overrun<=1, no request.
  3. fv_s=0 and (overrun or fifo_empty) → RST_WAIT, frame_written pulse.
  4. fv_s=0, 0<count<BURST_LEN, not overrun → FLUSH, mem_wr_req=1, mem_wr_partial=1.
- REQ: hold mem_wr_req=1 until mem_wr_ack is sampled high.
  - On ack: req drops next cycle, mem_wr_addr+=ADDR_INC (wraps modulo 2^ADDR_W), burst_count+=1, return to WRITE.
  - mem_wr_ack while not in REQ/FLUSH is ignored.
- FLUSH: like REQ with mem_wr_partial=1.
  - On ack: addr and count increment, frame_written pulse, go to RST_WAIT.
  - With BURST_LEN=1, FLUSH is unreachable.
- Timeout: the wait counter resets on entry to REQ/FLUSH. After ACK_TIMEOUT cycles without ack: drop req, timeout<=1, frame_written pulse, go to RST_WAIT.
- Minimum request spacing: one WRITE cycle between an ack and the next req.
- frame_valid rising again before RST_WAIT completes is ignored; the frame is lost.
- burst_count and sticky flags hold until the next frame start.

Test Plan:
- BURST_LEN=4, ADDR_INC=32, start_addr=0x100, 12 words, then fv low → 3 requests at 0x100, 0x120, 0x140; burst_count=3; frame_written once; fifo_reset high for 12 cycles.
- BURST_LEN=4, 10 words → 2 full requests, then a FLUSH request at 0x140 with mem_wr_partial=1; burst_count=3.
- MAX_BURSTS=2, 16 words available → exactly 2 requests; overrun=1; on fv low go straight to RST_WAIT with no flush.
- Ack held low for ACK_TIMEOUT cycles → req drops, timeout=1, frame_written pulses, ready returns after RST_CYCLES.
- reset_n pulsed low mid-REQ → mem_wr_req=0 immediately (async); later fv rising while ready starts a new frame at the new start_addr with burst_count=0.
- fv already high at IDLE entry → no requests until fv falls and rises again.
